layer_seq_ctrl: RTL
===================

// Module: layer_seq_ctrl
// PURPOSE
//   Multi-layer sequencer for the systolic datapath. Per layer: kicks weight load, input load
//   and valid pipeline; waits for both load completions; kicks layering; waits for layer
//   completion; repeats for num_layers layers. Sits above the weight/input loaders and the
//   layering engine. Adds done handshakes, watchdog timeout and abort to the open-loop kick sequence.
// PARAMETERS
//   LAYER_W     4     width of num_layers / layer_idx
//   TMO_W       11    width of watchdog counter
//   TMO_CYCLES  1024  max cycles allowed in any wait state (must be <= 2**TMO_W)
// PORTS
//   clk                   in   1        clock; all logic on rising edge
//   rst                   in   1        synchronous reset, active-high
//   start                 in   1        begin run; sampled only in IDLE
//   num_layers            in   LAYER_W  layers to run; captured on accepted start; 0 treated as 1
//   abort                 in   1        cancel run; return to IDLE
//   weights_done          in   1        1-cycle pulse: weight load finished
//   input_done            in   1        1-cycle pulse: input load finished
//   layer_done            in   1        1-cycle pulse: layering finished
//   mode                  out  3        0=IDLE, 1=LOAD, 2=LAYER
//   start_weights         out  1        1-cycle kick to weight loader
//   start_input           out  1        1-cycle kick to input loader
//   start_valid_pipeline  out  1        1-cycle kick to valid pipeline
//   start_layering        out  1        1-cycle kick to layering engine
//   layer_idx             out  LAYER_W  current layer, 0-based
//   busy                  out  1        high in any non-IDLE state
//   done                  out  1        1-cycle pulse: all layers completed
//   error                 out  1        sticky watchdog flag; cleared by accepted start or rst
// BEHAVIOUR
//   - All outputs registered. rst: state=IDLE, every output 0, load flags/counters 0.
//   - States: IDLE, WAIT_LOAD, WAIT_LAYER.
//   - IDLE: mode=0. On start: capture num_layers (0->1), layer_idx<=0, error<=0,
//     state<=WAIT_LOAD; start_weights/start_input/start_valid_pipeline high the cycle
//     after the start sample, for exactly 1 cycle.
//   - WAIT_LOAD: mode=1. Latch weights_done and input_done independently; any order or same cycle.
//     Once both are seen (latched or arriving this cycle): start_layering pulses the next cycle,
//     flags clear, state<=WAIT_LAYER.
//   - WAIT_LAYER: mode=2. On layer_done:
//       layer_idx == last: state<=IDLE, done=1 for 1 cycle, busy=0 in the same cycle.
//         layer_idx keeps its final value until the next start.
//       else: layer_idx+1, three load kicks pulse next cycle, state<=WAIT_LOAD.
//   - Done pulses outside their wait state (including IDLE) are ignored. A duplicate
//     weights_done/input_done within one WAIT_LOAD has no extra effect.
//   - Watchdog: counter clears on every state entry and increments each wait-state cycle.
//     If TMO_CYCLES cycles pass without progress: error<=1, state<=IDLE, no done, no kicks.
//   - abort in any non-IDLE state: next cycle IDLE, mode=0, busy=0, no done, error unchanged,
//     load flags cleared. abort wins over a same-cycle done input or timeout. Ignored in IDLE.
//   - start while busy is ignored. Kicks never overlap: at most one kick group per cycle.
//   - rst mid-run: same as reset; no done, no kick emitted.
// TESTING
//   1. num_layers=3, each done 5 cycles after its kick -> 3 load kick groups, 3 start_layering,
//      layer_idx 0,1,2, one done pulse, busy falls with done.
//   2. input_done 4 cycles before weights_done; repeat with both in the same cycle
//      -> start_layering exactly 1 cycle after the later (or common) done, once.
//   3. TMO_CYCLES=16, withhold layer_done -> error=1 and busy=0 after 16 WAIT_LAYER cycles,
//      no done; next start clears error and runs normally.
//   4. abort in WAIT_LOAD at layer_idx=1 -> IDLE next cycle, mode=0, no done, error=0;
//      a later layer_done is ignored.
//   5. start held high while busy, stray layer_done in IDLE, num_layers=0
//      -> no restart, no effect, exactly one layer run.
//   6. rst asserted in WAIT_LAYER -> all outputs 0 the next cycle; a fresh start works.

Source files
------------

// File: rtl/layer_seq_if.sv
// Handshake bundle between the layer sequencer and its surroundings.
// Kicks and done pulses are single-cycle strobes.
interface layer_seq_if #(
  parameter int LAYER_W = 4
);
  logic               start;
  logic [LAYER_W-1:0] num_layers;
  logic               abort;
  logic               weights_done;
  logic               input_done;
  logic               layer_done;
  logic [2:0]         mode;
  logic               start_weights;
  logic               start_input;
  logic               start_valid_pipeline;
  logic               start_layering;
  logic [LAYER_W-1:0] layer_idx;
  logic               busy;
  logic               done;
  logic               error;

  modport master (
    output start, num_layers, abort,
    output weights_done, input_done, layer_done,
    input  mode, start_weights, start_input,
    input  start_valid_pipeline, start_layering,
    input  layer_idx, busy, done, error
  );

  modport slave (
    input  start, num_layers, abort,
    input  weights_done, input_done, layer_done,
    output mode, start_weights, start_input,
    output start_valid_pipeline, start_layering,
    output layer_idx, busy, done, error
  );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Multi-layer sequencer: load kicks, layering kick, per-layer wait
// states with watchdog and abort. All outputs are registered.
module layer_seq_ctrl #(
  parameter int LAYER_W    = 4,
  parameter int TMO_W      = 11,
  parameter int TMO_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  layer_seq_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOAD,
    WAIT_LAYER
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TMO_CYCLES - 1);

  state_t             state;
  logic [LAYER_W-1:0] last;
  logic               w_seen;
  logic               i_seen;
  logic [TMO_W-1:0]   cnt;

  logic both;
  logic tmo;
  logic is_last;

  assign both = (w_seen | bus.weights_done) &
                (i_seen | bus.input_done);
  assign tmo = (cnt == TMO_LAST);
  assign is_last = (bus.layer_idx == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      last                     <= '0;
      w_seen                   <= 1'b0;
      i_seen                   <= 1'b0;
      cnt                      <= '0;
      bus.mode                 <= 3'd0;
      bus.start_weights        <= 1'b0;
      bus.start_input          <= 1'b0;
      bus.start_valid_pipeline <= 1'b0;
      bus.start_layering       <= 1'b0;
      bus.layer_idx            <= '0;
      bus.busy                 <= 1'b0;
      bus.done                 <= 1'b0;
      bus.error                <= 1'b0;
    end else begin
      bus.start_weights        <= 1'b0;
      bus.start_input          <= 1'b0;
      bus.start_valid_pipeline <= 1'b0;
      bus.start_layering       <= 1'b0;
      bus.done                 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= WAIT_LOAD;
            last  <= (bus.num_layers == '0) ? '0 :
                     bus.num_layers - LAYER_W'(1);
            cnt                      <= '0;
            w_seen                   <= 1'b0;
            i_seen                   <= 1'b0;
            bus.layer_idx            <= '0;
            bus.error                <= 1'b0;
            bus.mode                 <= 3'd1;
            bus.busy                 <= 1'b1;
            bus.start_weights        <= 1'b1;
            bus.start_input          <= 1'b1;
            bus.start_valid_pipeline <= 1'b1;
          end
        end
        WAIT_LOAD: begin
          // abort outranks completion, completion outranks timeout
          if (bus.abort) begin
            state    <= IDLE;
            w_seen   <= 1'b0;
            i_seen   <= 1'b0;
            cnt      <= '0;
            bus.mode <= 3'd0;
            bus.busy <= 1'b0;
          end else if (both) begin
            state              <= WAIT_LAYER;
            w_seen             <= 1'b0;
            i_seen             <= 1'b0;
            cnt                <= '0;
            bus.mode           <= 3'd2;
            bus.start_layering <= 1'b1;
          end else if (tmo) begin
            state     <= IDLE;
            w_seen    <= 1'b0;
            i_seen    <= 1'b0;
            cnt       <= '0;
            bus.mode  <= 3'd0;
            bus.busy  <= 1'b0;
            bus.error <= 1'b1;
          end else begin
            w_seen <= w_seen | bus.weights_done;
            i_seen <= i_seen | bus.input_done;
            cnt    <= cnt + TMO_W'(1);
          end
        end
        WAIT_LAYER: begin
          if (bus.abort) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.mode <= 3'd0;
            bus.busy <= 1'b0;
          end else if (bus.layer_done && is_last) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.mode <= 3'd0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else if (bus.layer_done) begin
            state                    <= WAIT_LOAD;
            cnt                      <= '0;
            bus.layer_idx            <= bus.layer_idx + LAYER_W'(1);
            bus.mode                 <= 3'd1;
            bus.start_weights        <= 1'b1;
            bus.start_input          <= 1'b1;
            bus.start_valid_pipeline <= 1'b1;
          end else if (tmo) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.mode  <= 3'd0;
            bus.busy  <= 1'b0;
            bus.error <= 1'b1;
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          bus.mode <= 3'd0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
